// File: rtl/mod3_tx_if.sv
// Word-in / bit-out handshake bundle for the mod-3 framing serializer.
interface mod3_tx_if #(
  parameter int WIDTH = 8
);
  logic             din_valid;
  logic [WIDTH-1:0] din;
  logic             din_ready;
  logic             sout;
  logic             sout_valid;
  logic             sout_last;

  modport master (
    output din_valid, din,
    input  din_ready, sout, sout_valid, sout_last
  );

  modport slave (
    input  din_valid, din,
    output din_ready, sout, sout_valid, sout_last
  );
endinterface

// File: rtl/mod3_tx.sv
// Serializes WIDTH-bit words MSB-first and appends two check bits so that
// every frame value is a multiple of 3; the residue is tracked bit by bit.
module mod3_tx #(
  parameter int WIDTH = 8
) (
  input  logic   clk,
  input  logic   rst,
  mod3_tx_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 2);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    CHK  = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] shift_reg, shift_next;
  logic [1:0]       res_reg, res_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic             sout_reg, sout_next;
  logic             valid_reg, valid_next;
  logic             last_reg, last_next;
  logic [1:0]       res_step;
  logic [1:0]       chk_step;
  logic [1:0]       chk_hold;

  // (2r + b) mod 3; the 2'b11 residue code is never produced.
  function automatic logic [1:0] res_update(input logic [1:0] r, input logic b);
    logic [1:0] v;
    case ({r, b})
      3'b000:  v = 2'd0;
      3'b001:  v = 2'd1;
      3'b010:  v = 2'd2;
      3'b011:  v = 2'd0;
      3'b100:  v = 2'd1;
      3'b101:  v = 2'd2;
      default: v = 2'd0;
    endcase
    return v;
  endfunction

  function automatic logic [1:0] chk_code(input logic [1:0] r);
    logic [1:0] c;
    case (r)
      2'd1:    c = 2'b10;
      2'd2:    c = 2'b01;
      default: c = 2'b00;
    endcase
    return c;
  endfunction

  // The bit currently on sout is the MSB of the shift register as it leaves.
  assign res_step = res_update(res_reg, shift_reg[WIDTH-1]);
  assign chk_step = chk_code(res_step);
  assign chk_hold = chk_code(res_reg);

  assign bus.din_ready  = (state_reg == IDLE);
  assign bus.sout       = sout_reg;
  assign bus.sout_valid = valid_reg;
  assign bus.sout_last  = last_reg;

  always_comb begin
    state_next = state_reg;
    shift_next = shift_reg;
    res_next   = res_reg;
    cnt_next   = cnt_reg;
    sout_next  = 1'b0;
    valid_next = 1'b0;
    last_next  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.din_valid) begin
          state_next = DATA;
          shift_next = bus.din;
          res_next   = 2'd0;
          cnt_next   = '0;
          sout_next  = bus.din[WIDTH-1];
          valid_next = 1'b1;
        end
      end
      DATA: begin
        res_next   = res_step;
        shift_next = {shift_reg[WIDTH-2:0], 1'b0};
        cnt_next   = cnt_reg + 1'b1;
        valid_next = 1'b1;
        if (cnt_reg == CW'(WIDTH - 1)) begin
          state_next = CHK;
          sout_next  = chk_step[1];
        end else begin
          sout_next  = shift_reg[WIDTH-2];
        end
      end
      CHK: begin
        if (cnt_reg == CW'(WIDTH)) begin
          sout_next  = chk_hold[0];
          valid_next = 1'b1;
          last_next  = 1'b1;
          cnt_next   = cnt_reg + 1'b1;
        end else begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
        shift_next = '0;
        res_next   = 2'd0;
        cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      shift_reg <= '0;
      res_reg   <= 2'd0;
      cnt_reg   <= '0;
      sout_reg  <= 1'b0;
      valid_reg <= 1'b0;
      last_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      shift_reg <= shift_next;
      res_reg   <= res_next;
      cnt_reg   <= cnt_next;
      sout_reg  <= sout_next;
      valid_reg <= valid_next;
      last_reg  <= last_next;
    end
  end
endmodule
